jump_branch: RTL and testbench

- Decode-stage jump/branch resolver for the DLX pipeline.
- Inspects the instruction in decode and decides whether control flow is redirected. When it is, it computes the redirect target PC and the link value for R31.
- Resolution path is purely combinational, so the control unit can assert Branch and kill the following instruction in the same cycle.
- A small clocked block keeps taken-transfer statistics for debug and verification.

---
 rtl/jump_branch_if.sv | 34 +++
 rtl/jump_branch.sv | 109 ++++++++++
 tb/tb_jump_branch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jump_branch_if.sv
// jump_branch_if
//   Groups the decode-stage signals exchanged between the control/decode side
//   and the jump/branch resolver.
//
//   master : decode/control side. It drives instruction, pc_plus_four, rs1
//            and fp_status, and it consumes outputPC, takeBranch and register31.
//   slave  : the resolver (jump_branch).
//
//   There is no valid/ready handshake on this interface. Every output is a
//   pure combinational function of the current inputs. The outputs are
//   meaningful in any cycle where the inputs are stable. takeBranch qualifies
//   outputPC, and register31 is always valid.
//
//   Bit numbering is descending [31:0]. Big-endian bit i of the instruction
//   is physical bit 31-i, so opcode [0:5] is instruction[31:26].
interface jump_branch_if;
  logic [31:0] instruction;
  logic [31:0] pc_plus_four;
  logic [31:0] rs1;
  logic        fp_status;
  logic [31:0] outputPC;
  logic        takeBranch;
  logic [31:0] register31;

  modport master (
    output instruction, pc_plus_four, rs1, fp_status,
    input  outputPC, takeBranch, register31
  );

  modport slave (
    input  instruction, pc_plus_four, rs1, fp_status,
    output outputPC, takeBranch, register31
  );
endinterface

// File: rtl/jump_branch.sv
// jump_branch
//   Decode-stage jump/branch resolver for the DLX pipeline. It decides
//   combinationally whether the decoded instruction redirects fetch. It
//   computes the redirect target and the R31 link value. A clocked
//   statistics block counts taken transfers and records the last target.
//
//   Ports:
//     clk          statistics clock
//     reset_n      asynchronous active-low reset (statistics only)
//     bus          jump_branch_if.slave: instruction, pc_plus_four, rs1,
//                  fp_status in; outputPC, takeBranch, register31 out
//     taken_count  saturating count of cycles with takeBranch=1
//     last_target  outputPC captured on the most recent taken cycle
module jump_branch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  jump_branch_if.slave     bus,
  output logic [CNT_W-1:0] taken_count,
  output logic [31:0]      last_target
);

  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQZ   = 6'h04;
  localparam logic [5:0] OP_BNEZ   = 6'h05;
  localparam logic [5:0] OP_BFPT   = 6'h06;
  localparam logic [5:0] OP_BFPF   = 6'h07;
  localparam logic [5:0] OP_JR_OLD = 6'h0C;
  localparam logic [5:0] OP_JR     = 6'h12;
  localparam logic [5:0] OP_JALR   = 6'h13;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [5:0]  opcode;
  logic [31:0] imm16;
  logic [31:0] imm26;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        take;
  logic [31:0] target;

  // Big-endian [0:5] is physical [31:26]; [16:31] is [15:0]; [6:31] is [25:0].
  assign opcode = bus.instruction[31:26];
  assign imm16  = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
  assign imm26  = {{6{bus.instruction[25]}}, bus.instruction[25:0]};

  // Modulo-2^32 adds; wrap-around is intentionally silent.
  assign branch_target = bus.pc_plus_four + imm16;
  assign jump_target   = bus.pc_plus_four + imm26;

  // Recognised branches drive their computed target even when not taken.
  // Unrecognised opcodes fall back to the sequential PC.
  always_comb begin
    take   = 1'b0;
    target = bus.pc_plus_four;
    unique case (opcode)
      OP_J, OP_JAL: begin
        take   = 1'b1;
        target = jump_target;
      end
      OP_BEQZ: begin
        take   = (bus.rs1 == 32'd0);
        target = branch_target;
      end
      OP_BNEZ: begin
        take   = (bus.rs1 != 32'd0);
        target = branch_target;
      end
      OP_BFPT: begin
        take   = bus.fp_status;
        target = branch_target;
      end
      OP_BFPF: begin
        take   = ~bus.fp_status;
        target = branch_target;
      end
      OP_JR, OP_JR_OLD, OP_JALR: begin
        take   = 1'b1;
        target = bus.rs1;  // no alignment check
      end
      default: begin
        take   = 1'b0;
        target = bus.pc_plus_four;
      end
    endcase
  end

  assign bus.takeBranch = take;
  assign bus.outputPC   = target;
  // No delay slot: the link is always the sequential PC; control decides
  // whether R31 is actually written.
  assign bus.register31 = bus.pc_plus_four;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_count <= '0;
      last_target <= '0;
    end else if (take) begin
      if (taken_count != CNT_MAX) begin
        taken_count <= taken_count + CNT_ONE;
      end
      last_target <= target;
    end
  end

endmodule

// File: tb/tb_jump_branch.sv
module tb_jump_branch;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic [CNT_W-1:0] taken_count;
  logic [31:0]      last_target;

  jump_branch_if bus ();

  jump_branch #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .taken_count (taken_count),
    .last_target (last_target)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [64:0]      exp_q[$];   // {take, target, register31}
  logic [CNT_W-1:0] exp_cnt;
  logic [31:0]      exp_last;
  int               n_vec;
  int               n_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- encoders and reference model ----------------
  function automatic logic [31:0] ity(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd0, imm};
  endfunction

  function automatic logic [31:0] jty(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [64:0] ref_model(input logic [31:0] ins, input logic [31:0] pc4,
                                            input logic [31:0] r1, input logic fp);
    logic [5:0]  op;
    logic [31:0] bt;
    logic [31:0] jt;
    op = ins[31:26];
    bt = pc4 + {{16{ins[15]}}, ins[15:0]};
    jt = pc4 + {{6{ins[25]}}, ins[25:0]};
    if (op == 6'h02 || op == 6'h03) return {1'b1, jt, pc4};
    if (op == 6'h04) return {(r1 == 0), bt, pc4};
    if (op == 6'h05) return {(r1 != 0), bt, pc4};
    if (op == 6'h06) return {fp, bt, pc4};
    if (op == 6'h07) return {~fp, bt, pc4};
    if (op == 6'h0C || op == 6'h12 || op == 6'h13) return {1'b1, r1, pc4};
    return {1'b0, pc4, pc4};
  endfunction

  // ---------------- driver ----------------
  // Drives one instruction for a full cycle, checks the combinational outputs,
  // then checks the statistics after the following posedge. If rel is set,
  // reset is released together with the new inputs.
  task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] r1, input logic fp, input logic [64:0] exp,
                       input logic rel);
    logic [64:0] e;
    @(negedge clk);
    bus.instruction  = ins;
    bus.pc_plus_four = pc4;
    bus.rs1          = r1;
    bus.fp_status    = fp;
    if (rel) reset_n = 1'b1;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".take"}, 64'(bus.takeBranch), 64'(e[64]));
    check_val({tag, ".pc"},   64'(bus.outputPC),   64'(e[63:32]));
    check_val({tag, ".r31"},  64'(bus.register31), 64'(e[31:0]));
    @(posedge clk);
    if (reset_n && e[64]) begin
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      exp_last = e[63:32];
    end
    #1;
    check_val({tag, ".cnt"},  64'(taken_count), 64'(exp_cnt));
    check_val({tag, ".last"}, 64'(last_target), 64'(exp_last));
  endtask

  // Asserts reset between edges and checks the asynchronous clear.
  task automatic reset_pulse(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    exp_cnt  = '0;
    exp_last = '0;
    check_val({tag, ".cnt"},  64'(taken_count), 64'(exp_cnt));
    check_val({tag, ".last"}, 64'(last_target), 64'(exp_last));
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_tab[13];

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_cnt  = '0;
    exp_last = '0;
    bus.instruction  = '0;
    bus.pc_plus_four = '0;
    bus.rs1          = '0;
    bus.fp_status    = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_val("rst.cnt",  64'(taken_count), 64'(0));
    check_val("rst.last", 64'(last_target), 64'(0));

    // Combinational outputs work while reset is held; the counters stay clear.
    apply("beqz_t",   ity(6'h04, 16'h0010), 32'h100, 32'd0, 1'b0, {1'b1, 32'h110, 32'h100}, 1'b0);
    apply("beqz_nt",  ity(6'h04, 16'h0010), 32'h100, 32'd5, 1'b0, {1'b0, 32'h110, 32'h100}, 1'b1);
    apply("beqz_neg", ity(6'h04, 16'hFFFC), 32'h100, 32'd0, 1'b0, {1'b1, 32'hFC, 32'h100}, 1'b0);
    apply("bnez_t",   ity(6'h05, 16'hFFF8), 32'h200, 32'd1, 1'b0, {1'b1, 32'h1F8, 32'h200}, 1'b0);
    apply("jal",      jty(6'h03, 26'h40), 32'h1000, 32'd0, 1'b0, {1'b1, 32'h1040, 32'h1000}, 1'b0);
    apply("jr",       ity(6'h12, 16'h0), 32'h3000, 32'hDEADBEEC, 1'b0, {1'b1, 32'hDEADBEEC, 32'h3000}, 1'b0);
    apply("jalr",     ity(6'h13, 16'h0), 32'h3004, 32'hDEADBEEC, 1'b0, {1'b1, 32'hDEADBEEC, 32'h3004}, 1'b0);
    apply("addi",     ity(6'h08, 16'h0010), 32'h400, 32'd0, 1'b0, {1'b0, 32'h400, 32'h400}, 1'b0);
    apply("bfpt_1",   ity(6'h06, 16'h0020), 32'h500, 32'd0, 1'b1, {1'b1, 32'h520, 32'h500}, 1'b0);
    apply("bfpt_0",   ity(6'h06, 16'h0020), 32'h500, 32'd0, 1'b0, {1'b0, 32'h520, 32'h500}, 1'b0);
    apply("bfpf_1",   ity(6'h07, 16'h0020), 32'h500, 32'd0, 1'b1, {1'b0, 32'h520, 32'h500}, 1'b0);
    apply("bfpf_0",   ity(6'h07, 16'h0020), 32'h500, 32'd0, 1'b0, {1'b1, 32'h520, 32'h500}, 1'b0);
    apply("jr_old",   ity(6'h0C, 16'h0), 32'h700, 32'h12345679, 1'b0, {1'b1, 32'h12345679, 32'h700}, 1'b0);
    apply("trap",     ity(6'h11, 16'h0040), 32'h600, 32'd0, 1'b0, {1'b0, 32'h600, 32'h600}, 1'b0);
    apply("rfe",      ity(6'h10, 16'h0040), 32'h604, 32'd0, 1'b0, {1'b0, 32'h604, 32'h604}, 1'b0);
    apply("j_neg",    jty(6'h02, 26'h3FFFFFC), 32'h0, 32'd0, 1'b0, {1'b1, 32'hFFFFFFFC, 32'h0}, 1'b0);
    apply("j_wrap",   jty(6'h02, 26'h20), 32'hFFFFFFF0, 32'd0, 1'b0, {1'b1, 32'h10, 32'hFFFFFFF0}, 1'b0);

    // Statistics: clear, three taken cycles, mid-cycle reset, and a release
    // in the same cycle as a taken branch.
    reset_pulse("clr");
    apply("rel_nt", ity(6'h08, 16'h0), 32'h800, 32'd0, 1'b0, {1'b0, 32'h800, 32'h800}, 1'b1);
    for (int i = 0; i < 3; i++)
      apply("tk3", jty(6'h02, 26'h100), 32'h900 + 32'(i * 4), 32'd0, 1'b0,
            {1'b1, 32'hA00 + 32'(i * 4), 32'h900 + 32'(i * 4)}, 1'b0);
    check_val("tk3.total", 64'(taken_count), 64'(3));
    reset_pulse("mid_rst");
    apply("rel_tk", jty(6'h02, 26'h8), 32'hB00, 32'd0, 1'b0, {1'b1, 32'hB08, 32'hB00}, 1'b1);
    check_val("rel_tk.total", 64'(taken_count), 64'(1));

    // Saturation of the CNT_W-bit counter.
    for (int i = 0; i < 17; i++)
      apply("sat", ity(6'h12, 16'h0), 32'hC00, 32'hC000 + 32'(i), 1'b0,
            {1'b1, 32'hC000 + 32'(i), 32'hC00}, 1'b0);
    check_val("sat.total", 64'(taken_count), 64'({CNT_W{1'b1}}));

    // Random vectors.
    op_tab = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0C, 6'h12, 6'h13,
               6'h10, 6'h11, 6'h08, 6'h00};
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      logic [31:0] pc4;
      logic [31:0] r1;
      logic        fp;
      op = op_tab[$urandom_range(0, 12)];
      if (op == 6'h00) op = 6'($urandom_range(0, 63));
      ins = {op, 26'($urandom)};
      pc4 = $urandom;
      r1  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      fp  = 1'($urandom_range(0, 1));
      apply("rand", ins, pc4, r1, fp, ref_model(ins, pc4, r1, fp), 1'b0);
    end

    if (exp_q.size() != 0) check_val("q_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
